// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: steers the RAM address to the scan position during
// active video and drains FIFO / brush writes, or a constant-colour clear sweep, during blanking.
// Latency: 1 cycle from grant (or clear load) to fb_we. Backpressure: one pending write;
// grants stall while it is held by active video.
//
// Configuration macro: FB_SCHED_AUTOCLEAR_EN
//   defined     -> reset lands in CLEAR (clear_busy=1) and a sweep runs on the first blanking slots
//   not defined -> reset lands in RUN (clear_busy=0); clearing only on i_clear_req
//
// Ports:
//   i_clk, i_reset_n          pixel clock, asynchronous active-low reset
//   i_enable                  pixel strobe; state advances only on enabled slots
//   i_display_on              active-video flag; writes are blocked while high
//   i_vga_hpos/i_vga_vpos     scan position, drives the RAM address during active video
//   i_fifo_*                  first-word-fall-through FIFO head; o_fifo_pop consumes it
//   i_brush_*                 held brush request; o_brush_ack consumes it
//   i_clear_req               single-cycle pulse starting / restarting the clear sweep
//   o_clear_busy              high while the clear sweep owns the write port
//   o_fb_we, o_fb_hpos/vpos, o_fb_rgb   framebuffer write port
module fb_write_sched #(
  parameter int X_WIRE_WIDTH = 10,
  parameter int Y_WIRE_WIDTH = 10,
  parameter int RGB_WIDTH    = 3,
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480,
  parameter int CLEAR_STEP_H = 8,
  parameter int CLEAR_STEP_V = 8,
  parameter logic [RGB_WIDTH-1:0] CLEAR_RGB = {RGB_WIDTH{1'b1}}
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_display_on,
  input  logic [X_WIRE_WIDTH-1:0] i_vga_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] i_vga_vpos,
  input  logic                    i_fifo_empty,
  input  logic [X_WIRE_WIDTH-1:0] i_fifo_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] i_fifo_vpos,
  input  logic [RGB_WIDTH-1:0]    i_fifo_rgb,
  output logic                    o_fifo_pop,
  input  logic                    i_brush_req,
  input  logic [X_WIRE_WIDTH-1:0] i_brush_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] i_brush_vpos,
  input  logic [RGB_WIDTH-1:0]    i_brush_rgb,
  output logic                    o_brush_ack,
  input  logic                    i_clear_req,
  output logic                    o_clear_busy,
  output logic                    o_fb_we,
  output logic [X_WIRE_WIDTH-1:0] o_fb_hpos,
  output logic [Y_WIRE_WIDTH-1:0] o_fb_vpos,
  output logic [RGB_WIDTH-1:0]    o_fb_rgb
);

  localparam int XW1 = X_WIRE_WIDTH + 1;
  localparam int YW1 = Y_WIRE_WIDTH + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

`ifdef FB_SCHED_AUTOCLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  // State and pending-write register
  state_t                  r_state;
  logic                    r_pending;
  logic [X_WIRE_WIDTH-1:0] r_wr_hpos;
  logic [Y_WIRE_WIDTH-1:0] r_wr_vpos;
  logic [RGB_WIDTH-1:0]    r_wr_rgb;
  // Clear cursor
  logic [X_WIRE_WIDTH-1:0] r_cx;
  logic [Y_WIRE_WIDTH-1:0] r_cy;
  // Round-robin pointer: 1 = FIFO was granted last, 0 = brush was granted last
  logic                    r_rr_fifo_last;

  state_t                  w_state_nxt;
  logic                    w_slot;
  logic                    w_grant_fifo;
  logic                    w_grant_brush;
  logic                    w_load;
  logic [X_WIRE_WIDTH-1:0] w_ld_hpos;
  logic [Y_WIRE_WIDTH-1:0] w_ld_vpos;
  logic [RGB_WIDTH-1:0]    w_ld_rgb;
  logic [X_WIRE_WIDTH-1:0] w_cx_nxt;
  logic [Y_WIRE_WIDTH-1:0] w_cy_nxt;
  logic                    w_rr_nxt;
  logic [X_WIRE_WIDTH:0]   w_cx_sum;
  logic [Y_WIRE_WIDTH:0]   w_cy_sum;
  logic                    w_row_end;
  logic                    w_col_end;

  // Write port: the pending write goes out on any blanking cycle, independent of the strobe.
  assign o_fb_we      = r_pending & ~i_display_on;
  assign o_fb_hpos    = i_display_on ? i_vga_hpos : r_wr_hpos;
  assign o_fb_vpos    = i_display_on ? i_vga_vpos : r_wr_vpos;
  assign o_fb_rgb     = r_wr_rgb;
  assign o_clear_busy = (r_state == ST_CLEAR);
  assign o_fifo_pop   = w_grant_fifo;
  assign o_brush_ack  = w_grant_brush;

  // A new load is possible when the register is empty or is being written out this cycle.
  // Gated with reset so the combinational strobes stay low while the block is held in reset.
  assign w_slot = i_reset_n & i_enable & ~i_display_on & (~r_pending | o_fb_we);

  // Cursor arithmetic one bit wider so the end-of-row / end-of-frame compare cannot wrap.
  assign w_cx_sum  = {1'b0, r_cx} + XW1'(CLEAR_STEP_H);
  assign w_cy_sum  = {1'b0, r_cy} + YW1'(CLEAR_STEP_V);
  assign w_row_end = (w_cx_sum >= XW1'(RESOLUTION_H));
  assign w_col_end = (w_cy_sum >= YW1'(RESOLUTION_V));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_fifo  = 1'b0;
    w_grant_brush = 1'b0;
    w_load        = 1'b0;
    w_ld_hpos     = r_wr_hpos;
    w_ld_vpos     = r_wr_vpos;
    w_ld_rgb      = r_wr_rgb;
    w_cx_nxt      = r_cx;
    w_cy_nxt      = r_cy;
    w_rr_nxt      = r_rr_fifo_last;

    case (r_state)
      ST_RUN: begin
        if (i_clear_req) begin
          // Clear wins over any grant this cycle; an already pending write still drains.
          w_state_nxt = ST_CLEAR;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
        end else if (w_slot) begin
          if (~i_fifo_empty && (~i_brush_req || ~r_rr_fifo_last)) begin
            w_grant_fifo = 1'b1;
          end else if (i_brush_req) begin
            w_grant_brush = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        if (i_clear_req) begin
          // Restart: this cycle's load is dropped and the sweep begins again at the origin.
          w_cx_nxt = '0;
          w_cy_nxt = '0;
        end else if (w_slot) begin
          w_load    = 1'b1;
          w_ld_hpos = r_cx;
          w_ld_vpos = r_cy;
          w_ld_rgb  = CLEAR_RGB;
          if (w_row_end) begin
            w_cx_nxt = '0;
            if (w_col_end) begin
              w_cy_nxt    = '0;
              w_state_nxt = ST_RUN;
            end else begin
              w_cy_nxt = w_cy_sum[Y_WIRE_WIDTH-1:0];
            end
          end else begin
            w_cx_nxt = w_cx_sum[X_WIRE_WIDTH-1:0];
          end
        end
      end

      default: w_state_nxt = RESET_STATE;
    endcase

    if (w_grant_fifo) begin
      w_load    = 1'b1;
      w_ld_hpos = i_fifo_hpos;
      w_ld_vpos = i_fifo_vpos;
      w_ld_rgb  = i_fifo_rgb;
      w_rr_nxt  = 1'b1;
    end else if (w_grant_brush) begin
      w_load    = 1'b1;
      w_ld_hpos = i_brush_hpos;
      w_ld_vpos = i_brush_vpos;
      w_ld_rgb  = i_brush_rgb;
      w_rr_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= RESET_STATE;
      r_pending      <= 1'b0;
      r_wr_hpos      <= '0;
      r_wr_vpos      <= '0;
      r_wr_rgb       <= '0;
      r_cx           <= '0;
      r_cy           <= '0;
      r_rr_fifo_last <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cx           <= w_cx_nxt;
      r_cy           <= w_cy_nxt;
      r_rr_fifo_last <= w_rr_nxt;
      if (w_load) begin
        r_pending <= 1'b1;
        r_wr_hpos <= w_ld_hpos;
        r_wr_vpos <= w_ld_vpos;
        r_wr_rgb  <= w_ld_rgb;
      end else if (o_fb_we) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
module tb_fb_write_sched;

`ifdef FB_SCHED_AUTOCLEAR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       display_on;
  logic [9:0] vga_hpos;
  logic [9:0] vga_vpos;
  logic       fifo_empty;
  logic [9:0] fifo_hpos;
  logic [9:0] fifo_vpos;
  logic [2:0] fifo_rgb;
  logic       fifo_pop;
  logic       brush_req;
  logic [9:0] brush_hpos;
  logic [9:0] brush_vpos;
  logic [2:0] brush_rgb;
  logic       brush_ack;
  logic       clear_req;
  logic       clear_busy;
  logic       fb_we;
  logic [9:0] fb_hpos;
  logic [9:0] fb_vpos;
  logic [2:0] fb_rgb;

  int n_cmp = 0;
  int n_err = 0;

  fb_write_sched dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_display_on(display_on),
    .i_vga_hpos(vga_hpos), .i_vga_vpos(vga_vpos),
    .i_fifo_empty(fifo_empty), .i_fifo_hpos(fifo_hpos), .i_fifo_vpos(fifo_vpos),
    .i_fifo_rgb(fifo_rgb), .o_fifo_pop(fifo_pop),
    .i_brush_req(brush_req), .i_brush_hpos(brush_hpos), .i_brush_vpos(brush_vpos),
    .i_brush_rgb(brush_rgb), .o_brush_ack(brush_ack),
    .i_clear_req(clear_req), .o_clear_busy(clear_busy),
    .o_fb_we(fb_we), .o_fb_hpos(fb_hpos), .o_fb_vpos(fb_vpos), .o_fb_rgb(fb_rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change right after the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    enable = 1'b1; display_on = 1'b0; vga_hpos = '0; vga_vpos = '0;
    fifo_empty = 1'b1; fifo_hpos = '0; fifo_vpos = '0; fifo_rgb = '0;
    brush_req = 1'b0; brush_hpos = '0; brush_vpos = '0; brush_rgb = '0;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    bit done;
    reset_n = 1'b0;
    idle_inputs();
    fifo_empty = 1'b0; fifo_hpos = 10'd3; fifo_vpos = 10'd4; fifo_rgb = 3'b101;
    brush_req = 1'b1;
    #1;
    n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL reset_fifo_pop: got %b want 0", fifo_pop); end
    n_cmp++; if (brush_ack !== 1'b0) begin n_err++; $display("FAIL reset_brush_ack: got %b want 0", brush_ack); end
    n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    n_cmp++; if (clear_busy !== AUTOCLR) begin n_err++; $display("FAIL reset_clear_busy: got %b want %b", clear_busy, AUTOCLR); end
    n_cmp++; if (fb_hpos !== 10'd0 || fb_vpos !== 10'd0 || fb_rgb !== 3'd0) begin
      n_err++; $display("FAIL reset_wr_regs: got (%0d,%0d,%0d) want (0,0,0)", fb_hpos, fb_vpos, fb_rgb);
    end
    display_on = 1'b1; vga_hpos = 10'd123; vga_vpos = 10'd45;
    #1;
    n_cmp++; if (fb_hpos !== 10'd123 || fb_vpos !== 10'd45) begin
      n_err++; $display("FAIL reset_scan_mux: got (%0d,%0d) want (123,45)", fb_hpos, fb_vpos);
    end
    tick();
    idle_inputs();
    reset_n = 1'b1;
    if (AUTOCLR) begin
      cnt = 0; done = 1'b0;
      for (int c = 0; c < 6000 && !done; c++) begin
        #1;
        if (fb_we) cnt++;
        if (!clear_busy && !fb_we) done = 1'b1;
        tick();
      end
      n_cmp++; if (cnt !== 4800) begin n_err++; $display("FAIL autoclear_count: got %0d want 4800", cnt); end
    end
    tick();
  endtask

  task automatic test_fifo_single();
    fifo_empty = 1'b0; fifo_hpos = 10'd5; fifo_vpos = 10'd7; fifo_rgb = 3'b010;
    #1;
    n_cmp++; if (fifo_pop !== 1'b1 || brush_ack !== 1'b0 || fb_we !== 1'b0) begin
      n_err++; $display("FAIL fifo_grant: got pop=%b ack=%b we=%b want 1 0 0", fifo_pop, brush_ack, fb_we);
    end
    tick();
    fifo_empty = 1'b1;
    #1;
    n_cmp++; if (fifo_pop !== 1'b0 || fb_we !== 1'b1 || fb_hpos !== 10'd5 || fb_vpos !== 10'd7 || fb_rgb !== 3'b010) begin
      n_err++; $display("FAIL fifo_write: got pop=%b we=%b (%0d,%0d,%0d) want 0 1 (5,7,2)",
                        fifo_pop, fb_we, fb_hpos, fb_vpos, fb_rgb);
    end
    tick();
    #1;
    n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL fifo_single_once: got we=%b want 0", fb_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit exp_fifo;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    fifo_empty = 1'b0; fifo_hpos = 10'd1;  fifo_vpos = 10'd2;  fifo_rgb = 3'b001;
    brush_req = 1'b1;  brush_hpos = 10'd30; brush_vpos = 10'd40; brush_rgb = 3'b100;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_fifo = (k % 2 == 0);
      n_cmp++; if (fifo_pop !== exp_fifo || brush_ack !== !exp_fifo) begin
        n_err++; $display("FAIL rr_grant_%0d: got pop=%b ack=%b want pop=%b ack=%b", k, fifo_pop, brush_ack, exp_fifo, !exp_fifo);
      end
      if (k > 0) begin
        // The write on screen is the previous grant: brush after an even k-1... i.e. FIFO if k is odd.
        n_cmp++; if (fb_we !== 1'b1 || fb_hpos !== (exp_fifo ? 10'd30 : 10'd1)) begin
          n_err++; $display("FAIL rr_write_%0d: got we=%b h=%0d want we=1 h=%0d", k, fb_we, fb_hpos, exp_fifo ? 30 : 1);
        end
      end
      tick();
    end
    fifo_empty = 1'b1; brush_req = 1'b0;
    #1;
    n_cmp++; if (fb_we !== 1'b1 || fb_hpos !== 10'd30 || fb_vpos !== 10'd40 || fb_rgb !== 3'b100 || fifo_pop !== 1'b0 || brush_ack !== 1'b0) begin
      n_err++; $display("FAIL rr_last_write: got we=%b (%0d,%0d,%0d) pop=%b ack=%b want 1 (30,40,4) 0 0",
                        fb_we, fb_hpos, fb_vpos, fb_rgb, fifo_pop, brush_ack);
    end
    tick();
    #1;
    n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rr_drained: got we=%b want 0", fb_we); end
    tick();
  endtask

  task automatic test_display_hold();
    int bad;
    fifo_empty = 1'b0; fifo_hpos = 10'd9; fifo_vpos = 10'd11; fifo_rgb = 3'b011;
    #1;
    n_cmp++; if (fifo_pop !== 1'b1) begin n_err++; $display("FAIL hold_grant: got pop=%b want 1", fifo_pop); end
    tick();
    display_on = 1'b1;
    fifo_hpos = 10'd50; fifo_vpos = 10'd60; fifo_rgb = 3'b110;
    brush_req = 1'b1; brush_hpos = 10'd30; brush_vpos = 10'd40; brush_rgb = 3'b100;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      vga_hpos = 10'(100 + i); vga_vpos = 10'd200;
      #1;
      if (fb_we !== 1'b0 || fb_hpos !== 10'(100 + i) || fb_vpos !== 10'd200 || fifo_pop !== 1'b0 || brush_ack !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_active_video: got %0d bad cycles want 0", bad); end
    display_on = 1'b0;
    #1;
    n_cmp++; if (fb_we !== 1'b1 || fb_hpos !== 10'd9 || fb_vpos !== 10'd11 || fb_rgb !== 3'b011) begin
      n_err++; $display("FAIL hold_release: got we=%b (%0d,%0d,%0d) want 1 (9,11,3)", fb_we, fb_hpos, fb_vpos, fb_rgb);
    end
    n_cmp++; if (brush_ack !== 1'b1 || fifo_pop !== 1'b0) begin
      n_err++; $display("FAIL hold_rr_brush: got ack=%b pop=%b want 1 0", brush_ack, fifo_pop);
    end
    tick();
    fifo_empty = 1'b1; brush_req = 1'b0;
    #1;
    n_cmp++; if (fb_we !== 1'b1 || fb_hpos !== 10'd30 || fb_rgb !== 3'b100) begin
      n_err++; $display("FAIL hold_next_write: got we=%b h=%0d rgb=%0d want 1 30 4", fb_we, fb_hpos, fb_rgb);
    end
    tick();
    #1;
    n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL hold_no_dup: got we=%b want 0", fb_we); end
    tick();
  endtask

  task automatic test_clear_sweep();
    int cnt, order_err, rgb_err, busy_err, extra, ex, ey, last_h, last_v;
    bit done;
    clear_req = 1'b1;
    fifo_empty = 1'b0; fifo_hpos = 10'd1; fifo_vpos = 10'd1; fifo_rgb = 3'b001;
    #1;
    n_cmp++; if (fifo_pop !== 1'b0 || clear_busy !== 1'b0) begin
      n_err++; $display("FAIL clear_suppress: got pop=%b busy=%b want 0 0", fifo_pop, clear_busy);
    end
    tick();
    clear_req = 1'b0; fifo_empty = 1'b1; enable = 1'b0;
    #1;
    n_cmp++; if (clear_busy !== 1'b1 || fb_we !== 1'b0) begin
      n_err++; $display("FAIL clear_enter: got busy=%b we=%b want 1 0", clear_busy, fb_we);
    end
    tick();
    cnt = 0; order_err = 0; rgb_err = 0; busy_err = 0; ex = 0; ey = 0; last_h = -1; last_v = -1; done = 1'b0;
    for (int c = 0; c < 12000 && !done; c++) begin
      enable = (c % 2 == 0);
      #1;
      if (fb_we) begin
        cnt++;
        if (fb_hpos !== 10'(ex) || fb_vpos !== 10'(ey)) order_err++;
        if (fb_rgb !== 3'b111) rgb_err++;
        if (clear_busy !== !(ex == 632 && ey == 472)) busy_err++;
        last_h = int'(fb_hpos); last_v = int'(fb_vpos);
        ex += 8;
        if (ex >= 640) begin ex = 0; ey += 8; end
      end
      if (!clear_busy && !fb_we) done = 1'b1;
      tick();
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      enable = 1'b1;
      #1;
      if (fb_we) extra++;
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL clear_timeout: got done=%b want 1", done); end
    n_cmp++; if (cnt !== 4800) begin n_err++; $display("FAIL clear_count: got %0d want 4800", cnt); end
    n_cmp++; if (last_h !== 632 || last_v !== 472) begin
      n_err++; $display("FAIL clear_last_pos: got (%0d,%0d) want (632,472)", last_h, last_v);
    end
    n_cmp++; if (order_err !== 0) begin n_err++; $display("FAIL clear_order: got %0d wrong positions want 0", order_err); end
    n_cmp++; if (rgb_err !== 0) begin n_err++; $display("FAIL clear_rgb: got %0d wrong colours want 0", rgb_err); end
    n_cmp++; if (busy_err !== 0) begin n_err++; $display("FAIL clear_busy_fall: got %0d wrong busy samples want 0", busy_err); end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL clear_after_end: got %0d extra writes want 0", extra); end
  endtask

  task automatic test_clear_restart();
    int cnt, order_err, ex, ey, first_h, first_v;
    bit phase, trig, done;
    enable = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0; order_err = 0; ex = 0; ey = 0; first_h = -1; first_v = -1;
    phase = 1'b0; trig = 1'b0; done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      #1;
      if (fb_we && phase) begin
        if (cnt == 0) begin first_h = int'(fb_hpos); first_v = int'(fb_vpos); end
        cnt++;
        if (fb_hpos !== 10'(ex) || fb_vpos !== 10'(ey)) order_err++;
        ex += 8;
        if (ex >= 640) begin ex = 0; ey += 8; end
      end
      // Write of (312,240) on screen means the cursor now sits at (320,240).
      if (fb_we && !phase && fb_hpos == 10'd312 && fb_vpos == 10'd240) begin
        clear_req = 1'b1;
        trig = 1'b1;
      end
      if (phase && !clear_busy && !fb_we) done = 1'b1;
      tick();
      clear_req = 1'b0;
      if (trig) phase = 1'b1;
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL restart_timeout: got done=%b want 1", done); end
    n_cmp++; if (first_h !== 0 || first_v !== 0) begin
      n_err++; $display("FAIL restart_first: got (%0d,%0d) want (0,0)", first_h, first_v);
    end
    n_cmp++; if (cnt !== 4800) begin n_err++; $display("FAIL restart_count: got %0d want 4800", cnt); end
    n_cmp++; if (order_err !== 0) begin n_err++; $display("FAIL restart_order: got %0d wrong positions want 0", order_err); end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int wr;
    bit seen;
    enable = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    #1;
    n_cmp++; if (fb_we !== 1'b1 || clear_busy !== 1'b1) begin
      n_err++; $display("FAIL midclear_pending: got we=%b busy=%b want 1 1", fb_we, clear_busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL midclear_reset_we: got %b want 0", fb_we); end
    n_cmp++; if (clear_busy !== AUTOCLR) begin n_err++; $display("FAIL midclear_reset_busy: got %b want %b", clear_busy, AUTOCLR); end
    tick();
    reset_n = 1'b1;
    if (AUTOCLR) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        #1;
        if (fb_we) begin
          seen = 1'b1;
          n_cmp++; if (fb_hpos !== 10'd0 || fb_vpos !== 10'd0) begin
            n_err++; $display("FAIL midclear_restart: got (%0d,%0d) want (0,0)", fb_hpos, fb_vpos);
          end
        end
        tick();
      end
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midclear_restart_timeout: got no write want one"); end
    end else begin
      wr = 0;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (fb_we) wr++;
        tick();
      end
      n_cmp++; if (wr !== 0 || clear_busy !== 1'b0) begin
        n_err++; $display("FAIL midclear_idle: got %0d writes busy=%b want 0 0", wr, clear_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_single();
    test_back_to_back();
    test_display_hold();
    test_clear_sweep();
    test_clear_restart();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
